// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter.
//   master_id_t : identifies a master (0 = CPU data bridge, 1 = DMA engine)
//   DEF_*       : default address/data width and outstanding-read depth
package sdram_arb_pkg;

  typedef logic master_id_t;

  localparam master_id_t ID_CPU = 1'b0;
  localparam master_id_t ID_DMA = 1'b1;

  localparam int DEF_ADDR_W   = 25;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_PEND = 8;
  localparam int NUM_MASTERS  = 2;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM port bundle used for both master-side ports and the SDRAM
// controller slave port.
//   master modport : drives the command (address/read/write/writedata/
//                    byteenable), receives waitrequest/readdata/readdatavalid
//   slave modport  : the reverse view
// Handshake: a command is transferred in the cycle where read or write is
// high and waitrequest is low; while waitrequest is high the master holds the
// command unchanged. Read data returns later, one word per readdatavalid
// pulse, in the order the reads were accepted.
interface sdram_port_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO remembering which master issued each outstanding read.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_id at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest entry
//   count      : number of stored entries (0..DEPTH)
//   full/empty : count == DEPTH / count == 0
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_PEND,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  master_id_t       push_id,
  input  logic             pop,
  output master_id_t       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  master_id_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller slave.
//   clk, reset : system clock, asynchronous active-high reset
//   m0         : CPU data bridge port (slave view)
//   m1         : DMA engine port (slave view)
//   s          : SDRAM controller port (master view)
//   err_stray  : sticky, read data arrived with no read outstanding
//   pend_count : outstanding reads
// Command path is combinational; read returns are steered by a tag FIFO.
// Build option SDRAM_ARB_FIXED_PRIO_EN: master 0 always wins contention
// (a stalled grant stays locked); otherwise grants alternate round-robin.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_PEND = DEF_MAX_PEND,
  localparam int CNT_W   = $clog2(MAX_PEND) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  sdram_port_arbiter_if.slave     m0,
  sdram_port_arbiter_if.slave     m1,
  sdram_port_arbiter_if.master    s,
  output logic                    err_stray,
  output logic [CNT_W-1:0]        pend_count
);

  logic       req0, req1, elig0, elig1;
  logic       gnt_valid;
  master_id_t gnt_id;
  logic       lock;
  master_id_t lock_id;
  master_id_t rr_prio;
  logic       accept, push, pop;
  logic       fifo_full, fifo_empty;
  master_id_t fifo_head;

  assign req0  = m0.read | m0.write;
  assign req1  = m1.read | m1.write;
  // Full blocks reads only, and uses the count before any same-cycle pop.
  assign elig0 = m0.write | (m0.read & !fifo_full);
  assign elig1 = m1.write | (m1.read & !fifo_full);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ID_CPU;
    if (reset) begin
      gnt_valid = 1'b0;
    end else if (lock) begin
      gnt_id    = lock_id;
      gnt_valid = (lock_id == ID_DMA) ? req1 : req0;
    end else if (elig0 && elig1) begin
      gnt_valid = 1'b1;
      gnt_id    = rr_prio;
    end else if (elig0) begin
      gnt_valid = 1'b1;
    end else if (elig1) begin
      gnt_valid = 1'b1;
      gnt_id    = ID_DMA;
    end
  end

  // Command mux; everything zero when idle.
  always_comb begin
    s.address    = '0;
    s.read       = 1'b0;
    s.write      = 1'b0;
    s.writedata  = '0;
    s.byteenable = '0;
    if (gnt_valid) begin
      if (gnt_id == ID_DMA) begin
        s.address    = m1.address;
        s.read       = m1.read;
        s.write      = m1.write;
        s.writedata  = m1.writedata;
        s.byteenable = m1.byteenable;
      end else begin
        s.address    = m0.address;
        s.read       = m0.read;
        s.write      = m0.write;
        s.writedata  = m0.writedata;
        s.byteenable = m0.byteenable;
      end
    end
  end

  assign m0.waitrequest = !(gnt_valid && gnt_id == ID_CPU) | s.waitrequest;
  assign m1.waitrequest = !(gnt_valid && gnt_id == ID_DMA) | s.waitrequest;

  assign accept = gnt_valid & !s.waitrequest;
  assign push   = accept & s.read;
  // A return with nothing outstanding is not popped and routed nowhere.
  assign pop    = s.readdatavalid & !fifo_empty & !reset;

  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = pop & (fifo_head == ID_CPU);
  assign m1.readdatavalid = pop & (fifo_head == ID_DMA);

  // Lock holds whenever the granted command is stalled, so the grant cannot
  // move mid-stall; it drops on accept (or if the request vanishes).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock      <= 1'b0;
      lock_id   <= ID_CPU;
      err_stray <= 1'b0;
    end else begin
      lock    <= gnt_valid & s.waitrequest;
      lock_id <= gnt_id;
      if (s.readdatavalid && fifo_empty) err_stray <= 1'b1;
    end
  end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign rr_prio = ID_CPU;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_prio <= ID_CPU;
    else if (accept) rr_prio <= ~gnt_id;
  end
`endif

  sdram_arb_tag_fifo #(.DEPTH(MAX_PEND)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (gnt_id),
    .pop     (pop),
    .head    (fifo_head),
    .count   (pend_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 32;
  localparam int MAX_PEND = 8;
  localparam int CNT_W    = $clog2(MAX_PEND) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

  logic             err_stray;
  logic [CNT_W-1:0] pend_count;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0         (m0_if.slave),
    .m1         (m1_if.slave),
    .s          (s_if.master),
    .err_stray  (err_stray),
    .pend_count (pend_count)
  );

  // ---------------- reference model ----------------
  // Outstanding reads as a queue of issuing master ids, oldest first.
  logic [0:0] exp_q[$];
  bit m_rr, m_lock, m_lock_id, m_err;
  bit e_gv, e_gid, e_wait0, e_wait1;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Who should own the slave port this cycle, from the arbitration rules.
  task automatic compute_grant();
    bit r0, r1, el0, el1, room;
    r0   = m0_if.read | m0_if.write;
    r1   = m1_if.read | m1_if.write;
    room = exp_q.size() < MAX_PEND;
    el0  = m0_if.write | (m0_if.read & room);
    el1  = m1_if.write | (m1_if.read & room);
    if (m_lock) begin
      e_gid = m_lock_id;
      e_gv  = m_lock_id ? r1 : r0;
    end else if (el0 && el1) begin
      e_gv  = 1'b1;
      e_gid = m_rr;
    end else begin
      e_gv  = el0 | el1;
      e_gid = !el0;
    end
  endtask

  task automatic check_outputs();
    logic [ADDR_W-1:0]   a;
    logic [DATA_W-1:0]   d;
    logic [DATA_W/8-1:0] be;
    bit rd, wr, rdv0, rdv1;
    compute_grant();
    a = '0; d = '0; be = '0; rd = 0; wr = 0;
    if (e_gv) begin
      a  = e_gid ? m1_if.address    : m0_if.address;
      d  = e_gid ? m1_if.writedata  : m0_if.writedata;
      be = e_gid ? m1_if.byteenable : m0_if.byteenable;
      rd = e_gid ? m1_if.read       : m0_if.read;
      wr = e_gid ? m1_if.write      : m0_if.write;
    end
    e_wait0 = !(e_gv && e_gid == 1'b0) || s_if.waitrequest;
    e_wait1 = !(e_gv && e_gid == 1'b1) || s_if.waitrequest;
    rdv0 = s_if.readdatavalid && exp_q.size() > 0 && exp_q[0] == 1'b0;
    rdv1 = s_if.readdatavalid && exp_q.size() > 0 && exp_q[0] == 1'b1;
    check("s_address", s_if.address, a);
    check("s_read", s_if.read, rd);
    check("s_write", s_if.write, wr);
    check("s_writedata", s_if.writedata, d);
    check("s_byteenable", s_if.byteenable, be);
    check("m0_waitrequest", m0_if.waitrequest, e_wait0);
    check("m1_waitrequest", m1_if.waitrequest, e_wait1);
    check("m0_readdatavalid", m0_if.readdatavalid, rdv0);
    check("m1_readdatavalid", m1_if.readdatavalid, rdv1);
    check("m0_readdata", m0_if.readdata, s_if.readdata);
    check("m1_readdata", m1_if.readdata, s_if.readdata);
    check("pend_count", pend_count, exp_q.size());
    check("err_stray", err_stray, m_err);
  endtask

  task automatic update_model();
    bit acc, rd;
    acc = e_gv && !s_if.waitrequest;
    rd  = e_gid ? m1_if.read : m0_if.read;
    if (s_if.readdatavalid) begin
      if (exp_q.size() == 0) m_err = 1'b1;
      else void'(exp_q.pop_front());
    end
    if (acc) begin
      if (rd) exp_q.push_back(e_gid);
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      m_rr = !e_gid;
`endif
    end
    m_lock    = e_gv && s_if.waitrequest;
    m_lock_id = e_gid;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_m(input int idx, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] be);
    if (idx == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.writedata = d; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.writedata = d; m1_if.byteenable = be;
    end
  endtask

  task automatic drive_s(input bit w, input bit rdv, input logic [DATA_W-1:0] rdata);
    s_if.waitrequest = w; s_if.readdatavalid = rdv; s_if.readdata = rdata;
  endtask

  task automatic settle();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic advance();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_s_read", s_if.read, 1'b0);
    check("rst_s_write", s_if.write, 1'b0);
    check("rst_m0_waitrequest", m0_if.waitrequest, 1'b1);
    check("rst_m1_waitrequest", m1_if.waitrequest, 1'b1);
    check("rst_m0_readdatavalid", m0_if.readdatavalid, 1'b0);
    check("rst_m1_readdatavalid", m1_if.readdatavalid, 1'b0);
    check("rst_pend_count", pend_count, 0);
    check("rst_err_stray", err_stray, 1'b0);
    exp_q.delete();
    m_rr = 0; m_lock = 0; m_lock_id = 0; m_err = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    drive_m(0, 0, 0, '0, '0, '0);
    drive_m(1, 0, 0, '0, '0, '0);
    drive_s(0, 0, '0);
    do_reset();

    // Single write from m0.
    drive_m(0, 0, 1, 25'h0000010, 32'hDEADBEEF, 4'hF);
    settle();
    check("wr_s_write", s_if.write, 1'b1);
    check("wr_s_address", s_if.address, 25'h0000010);
    check("wr_s_writedata", s_if.writedata, 32'hDEADBEEF);
    check("wr_m0_waitrequest", m0_if.waitrequest, 1'b0);
    advance();
    drive_m(0, 0, 0, '0, '0, '0);
    cycle();
    check("wr_pend_count", pend_count, 0);

    // Contention: both read every cycle; grants alternate from a fresh reset.
    do_reset();
    drive_m(0, 1, 0, 25'h0A0, '0, 4'hF);
    drive_m(1, 1, 0, 25'h0B0, '0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      settle();
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      check("rr_grant_addr", s_if.address, (i % 2 == 0) ? 25'h0A0 : 25'h0B0);
`endif
      advance();
    end
    drive_m(0, 0, 0, '0, '0, '0);
    drive_m(1, 0, 0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      drive_s(0, 1, 32'(i + 1));
      settle();
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      check("rr_ret_m0", m0_if.readdatavalid, (i % 2 == 0));
      check("rr_ret_m1", m1_if.readdatavalid, (i % 2 == 1));
`endif
      check("rr_ret_data", m0_if.readdata, 32'(i + 1));
      advance();
    end
    drive_s(0, 0, '0);

    // Stall lock: m1 granted at 0x100 and held for 3 stalled cycles.
    drive_m(1, 1, 0, 25'h100, '0, 4'hF);
    drive_s(1, 0, '0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lock_s_address", s_if.address, 25'h100);
      check("lock_m0_waitrequest", m0_if.waitrequest, 1'b1);
      advance();
      drive_m(0, 1, 0, 25'h200, '0, 4'hF);
    end
    drive_s(0, 0, '0);
    settle();
    check("lock_accept_m1", m1_if.waitrequest, 1'b0);
    check("lock_accept_addr", s_if.address, 25'h100);
    advance();
    drive_m(1, 0, 0, '0, '0, '0);
    settle();
    check("lock_next_m0", m0_if.waitrequest, 1'b0);
    check("lock_next_addr", s_if.address, 25'h200);
    advance();
    drive_m(0, 0, 0, '0, '0, '0);
    drive_s(0, 1, 32'h55);
    cycle();
    cycle();
    drive_s(0, 0, '0);

    // Full tag FIFO.
    do_reset();
    for (int i = 0; i < MAX_PEND; i++) begin
      drive_m(0, 1, 0, ADDR_W'(i), '0, 4'hF);
      cycle();
    end
    drive_m(1, 0, 1, 25'h300, 32'h12345678, 4'h3);
    settle();
    check("full_pend_count", pend_count, MAX_PEND);
    check("full_s_read", s_if.read, 1'b0);
    check("full_s_write", s_if.write, 1'b1);
    check("full_m0_waitrequest", m0_if.waitrequest, 1'b1);
    advance();
    drive_m(1, 0, 0, '0, '0, '0);
    drive_s(0, 1, 32'hA5A5A5A5);
    settle();
    check("full_pop_blocks_read", m0_if.waitrequest, 1'b1);
    check("full_pop_rdv", m0_if.readdatavalid, 1'b1);
    advance();
    drive_s(0, 0, '0);
    settle();
    check("full_after_pop_count", pend_count, MAX_PEND - 1);
    check("full_after_pop_read_ok", m0_if.waitrequest, 1'b0);
    advance();
    drive_m(0, 0, 0, '0, '0, '0);
    drive_s(0, 1, 32'h77);
    for (int i = 0; i < MAX_PEND; i++) cycle();
    drive_s(0, 0, '0);
    cycle();

    // Stray return.
    drive_s(0, 1, 32'h99);
    settle();
    check("stray_no_rdv0", m0_if.readdatavalid, 1'b0);
    check("stray_no_rdv1", m1_if.readdatavalid, 1'b0);
    advance();
    drive_s(0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stray_sticky", err_stray, 1'b1);
      advance();
    end

    // Randomized traffic with Avalon hold rules on the masters.
    for (int c = 0; c < 1500; c++) begin
      int pick;
      if (!((m0_if.read | m0_if.write) && e_wait0)) begin
        pick = $urandom_range(0, 2);
        drive_m(0, pick == 1, pick == 2, ADDR_W'($urandom), $urandom, 4'($urandom));
      end
      if (!((m1_if.read | m1_if.write) && e_wait1)) begin
        pick = $urandom_range(0, 2);
        drive_m(1, pick == 1, pick == 2, ADDR_W'($urandom), $urandom, 4'($urandom));
      end
      if (exp_q.size() > 0)
        drive_s($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom);
      else
        drive_s($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, $urandom);
      cycle();
    end
    drive_m(0, 0, 0, '0, '0, '0);
    drive_m(1, 0, 0, '0, '0, '0);
    drive_s(0, 0, '0);
    cycle();

    // Reset mid-operation with 3 reads outstanding and m1 locked in a stall.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_m(0, 1, 0, ADDR_W'(25'h400 + i), '0, 4'hF);
      cycle();
    end
    drive_m(0, 0, 0, '0, '0, '0);
    drive_m(1, 1, 0, 25'h500, '0, 4'hF);
    drive_s(1, 0, '0);
    cycle();
    check("mid_pend_before", pend_count, 3);
    drive_m(0, 1, 0, 25'h600, '0, 4'hF);
    do_reset();
    drive_s(0, 0, '0);
    settle();
    check("mid_lock_cleared", s_if.address, 25'h600);
    check("mid_pend_after", pend_count, 0);
    advance();
    drive_m(0, 0, 0, '0, '0, '0);
    drive_m(1, 0, 0, '0, '0, '0);
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
